// File: rtl/id_ex_pipe_reg_if.sv
// Bundle of ID-side inputs, MEM/WB bypass inputs and EX-side outputs
// for the ID/EX pipeline register.
interface id_ex_pipe_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic              i_stall;
  logic              i_flush;
  logic              i_id_valid;
  logic [XLEN-1:0]   i_id_pc;
  logic [4:0]        i_id_rs1;
  logic [4:0]        i_id_rs2;
  logic [4:0]        i_id_rd;
  logic              i_id_use_rs1;
  logic              i_id_use_rs2;
  logic [XLEN-1:0]   i_id_rs1_data;
  logic [XLEN-1:0]   i_id_rs2_data;
  logic [XLEN-1:0]   i_id_imm;
  logic [3:0]        i_id_alu_op;
  logic              i_id_alu_src;
  logic              i_id_mem_read;
  logic              i_id_mem_write;
  logic              i_id_reg_write;
  logic [1:0]        i_id_wb_sel;
  logic [4:0]        i_wb_rd;
  logic              i_wb_reg_write;
  logic [XLEN-1:0]   i_wb_data;

  logic              o_ex_valid;
  logic [XLEN-1:0]   o_ex_pc;
  logic [XLEN-1:0]   o_ex_rs1_data;
  logic [XLEN-1:0]   o_ex_rs2_data;
  logic [XLEN-1:0]   o_ex_imm;
  logic [4:0]        o_ex_rs1;
  logic [4:0]        o_ex_rs2;
  logic [4:0]        o_ex_rd;
  logic [3:0]        o_ex_alu_op;
  logic              o_ex_alu_src;
  logic              o_ex_mem_read;
  logic              o_ex_mem_write;
  logic              o_ex_reg_write;
  logic [1:0]        o_ex_wb_sel;
  logic              o_id_hold;
  logic [CNT_W-1:0]  o_bubble_cnt;

  modport master (
    output i_stall, i_flush, i_id_valid, i_id_pc, i_id_rs1, i_id_rs2, i_id_rd,
           i_id_use_rs1, i_id_use_rs2, i_id_rs1_data, i_id_rs2_data, i_id_imm,
           i_id_alu_op, i_id_alu_src, i_id_mem_read, i_id_mem_write,
           i_id_reg_write, i_id_wb_sel, i_wb_rd, i_wb_reg_write, i_wb_data,
    input  o_ex_valid, o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm,
           o_ex_rs1, o_ex_rs2, o_ex_rd, o_ex_alu_op, o_ex_alu_src,
           o_ex_mem_read, o_ex_mem_write, o_ex_reg_write, o_ex_wb_sel,
           o_id_hold, o_bubble_cnt
  );

  modport slave (
    input  i_stall, i_flush, i_id_valid, i_id_pc, i_id_rs1, i_id_rs2, i_id_rd,
           i_id_use_rs1, i_id_use_rs2, i_id_rs1_data, i_id_rs2_data, i_id_imm,
           i_id_alu_op, i_id_alu_src, i_id_mem_read, i_id_mem_write,
           i_id_reg_write, i_id_wb_sel, i_wb_rd, i_wb_reg_write, i_wb_data,
    output o_ex_valid, o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm,
           o_ex_rs1, o_ex_rs2, o_ex_rd, o_ex_alu_op, o_ex_alu_src,
           o_ex_mem_read, o_ex_mem_write, o_ex_reg_write, o_ex_wb_sel,
           o_id_hold, o_bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, stall/flush
// handling, write-back bypass on capture and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  id_ex_pipe_reg_if.slave  bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic [1:0]      wb_sel;
  } ex_t;

  ex_t              ex_q, ex_d, cap;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             byp_rs1, byp_rs2;

  always_comb begin
    load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & bus.i_id_valid &
               ((bus.i_id_use_rs1 & (bus.i_id_rs1 == ex_q.rd)) |
                (bus.i_id_use_rs2 & (bus.i_id_rs2 == ex_q.rd)));

    // x0 is never bypassed, so the register file's hardwired zero survives.
    byp_rs1 = bus.i_wb_reg_write & (bus.i_wb_rd != 5'd0) & (bus.i_wb_rd == bus.i_id_rs1);
    byp_rs2 = bus.i_wb_reg_write & (bus.i_wb_rd != 5'd0) & (bus.i_wb_rd == bus.i_id_rs2);

    cap.valid     = bus.i_id_valid;
    cap.pc        = bus.i_id_pc;
    cap.rs1_data  = byp_rs1 ? bus.i_wb_data : bus.i_id_rs1_data;
    cap.rs2_data  = byp_rs2 ? bus.i_wb_data : bus.i_id_rs2_data;
    cap.imm       = bus.i_id_imm;
    cap.rs1       = bus.i_id_rs1;
    cap.rs2       = bus.i_id_rs2;
    cap.rd        = bus.i_id_rd;
    cap.alu_op    = bus.i_id_alu_op;
    cap.alu_src   = bus.i_id_alu_src   & bus.i_id_valid;
    cap.mem_read  = bus.i_id_mem_read  & bus.i_id_valid;
    cap.mem_write = bus.i_id_mem_write & bus.i_id_valid;
    cap.reg_write = bus.i_id_reg_write & bus.i_id_valid;
    cap.wb_sel    = bus.i_id_wb_sel;

    ex_d  = ex_q;
    cnt_d = cnt_q;
    // Stall dominates flush; MEM re-issues the flush once the stall drops.
    if (!bus.i_stall) begin
      if (bus.i_flush) begin
        ex_d = '0;
      end else if (load_use) begin
        ex_d = '0;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ex_d = cap;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.o_ex_valid     = ex_q.valid;
  assign bus.o_ex_pc        = ex_q.pc;
  assign bus.o_ex_rs1_data  = ex_q.rs1_data;
  assign bus.o_ex_rs2_data  = ex_q.rs2_data;
  assign bus.o_ex_imm       = ex_q.imm;
  assign bus.o_ex_rs1       = ex_q.rs1;
  assign bus.o_ex_rs2       = ex_q.rs2;
  assign bus.o_ex_rd        = ex_q.rd;
  assign bus.o_ex_alu_op    = ex_q.alu_op;
  assign bus.o_ex_alu_src   = ex_q.alu_src;
  assign bus.o_ex_mem_read  = ex_q.mem_read;
  assign bus.o_ex_mem_write = ex_q.mem_write;
  assign bus.o_ex_reg_write = ex_q.reg_write;
  assign bus.o_ex_wb_sel    = ex_q.wb_sel;
  assign bus.o_id_hold      = bus.i_stall | (load_use & ~bus.i_flush);
  assign bus.o_bubble_cnt   = cnt_q;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register feeding the EX stage and the forwarding unit.
- Latches decoded operands and control, and supplies the registered rs1/rs2/rd fields that the forwarding unit compares against EX/MEM and MEM/WB.
- Detects load-use hazards, inserts bubbles, honours global stall/flush, and applies write-back bypass so ID never latches stale register-file data.
- Counts inserted bubbles for performance monitoring.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the bubble counter (saturating).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_stall  in  1  global stall from MEM (dmem busy); holds all state.
- i_flush  in  1  EX-resolved branch/jump mispredict; kills the ID instruction.
- i_id_valid  in  1  ID holds a real instruction.
- i_id_pc  in  XLEN  PC of the ID instruction.
- i_id_rs1, i_id_rs2, i_id_rd  in  5 each  register indices.
- i_id_use_rs1, i_id_use_rs2  in  1 each  instruction actually reads rs1/rs2.
- i_id_rs1_data, i_id_rs2_data  in  XLEN each  register-file read data.
- i_id_imm  in  XLEN  decoded immediate.
- i_id_alu_op  in  4  ALU operation.
- i_id_alu_src  in  1  0 = rs2, 1 = imm.
- i_id_mem_read, i_id_mem_write, i_id_reg_write  in  1 each  control.
- i_id_wb_sel  in  2  write-back select (00 ALU, 01 mem, 10 PC+4).
- i_wb_rd  in  5  MEM/WB destination.
- i_wb_reg_write  in  1  MEM/WB write enable.
- i_wb_data  in  XLEN  MEM/WB write data.
- o_ex_valid  out  1  EX slot holds a real instruction.
- o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm  out  XLEN each  registered copies.
- o_ex_rs1, o_ex_rs2, o_ex_rd  out  5 each  registered indices; to the forwarding unit.
- o_ex_alu_op  out  4  registered.
- o_ex_alu_src, o_ex_mem_read, o_ex_mem_write, o_ex_reg_write  out  1 each  registered, gated by valid.
- o_ex_wb_sel  out  2  registered.
- o_id_hold  out  1  combinational; PC and IF/ID must hold this cycle.
- o_bubble_cnt  out  CNT_W  saturating count of load-use bubbles inserted.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): all registered outputs 0, o_ex_valid=0, o_bubble_cnt=0. Reset overrides every other input; asserting it mid-stall or mid-flush clears the stage.
- load_use (combinational):
  - Required conditions: o_ex_valid & o_ex_mem_read & o_ex_rd!=0 & i_id_valid.
  - Plus at least one of: (i_id_use_rs1 & i_id_rs1==o_ex_rd) or (i_id_use_rs2 & i_id_rs2==o_ex_rd).
- o_id_hold = i_stall | (load_use & ~i_flush).
- Next-state priority at each rising edge:
  1. Reset.
  2. i_stall=1: hold every register unchanged, including the counter. The stall dominates the flush; the MEM stage reasserts the flush after release.
  3. i_flush=1: load a bubble (valid=0, all control and indices 0, data 0).
  4. load_use=1: load a bubble; o_bubble_cnt += 1, saturating at all-ones.
  5. Otherwise: capture ID inputs. o_ex_valid=i_id_valid. Control bits are ANDed with i_id_valid.
- Bubble definition: o_ex_valid=0, o_ex_reg_write=0, o_ex_mem_read=0, o_ex_mem_write=0, o_ex_rd=0, o_ex_rs1=0, o_ex_rs2=0. The zeroed indices mean the forwarding unit sees no matches.
- WB bypass on capture:
  - If i_wb_reg_write & i_wb_rd!=0 & i_wb_rd==i_id_rs1, latch i_wb_data into o_ex_rs1_data instead of i_id_rs1_data. rs2 is handled identically.
  - Bypass applies even if i_id_use_rsX=0 (harmless).
  - x0 is never bypassed.
- Latency: one cycle from ID inputs to o_ex_*.
- One load-use bubble per hazard. After the bubble, the load sits in MEM and the forwarding unit covers the dependence.
- Counter saturates; it never wraps to 0.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with i_id_valid=1 and all inputs nonzero -> all outputs 0, o_bubble_cnt=0; first capture happens on the edge after release.
- Plain capture: i_id_pc=0x100, rs1=5, rs2=6, rd=7, imm=0x10, reg_write=1 -> next cycle o_ex_pc=0x100, o_ex_rd=7, o_ex_reg_write=1, o_ex_valid=1, o_id_hold=0.
- Load-use:
  - Stimulus: EX holds lw with rd=5; ID holds add reading rs1=5.
  - Required: o_id_hold=1 that cycle; next cycle EX is a bubble (valid=0, rd=0) and o_bubble_cnt=1.
  - Repeat with rd=0 in EX -> no hold, no bubble.
- Flush vs load-use: load_use and i_flush both 1 -> bubble loaded, o_id_hold=0, o_bubble_cnt unchanged.
- Stall: i_stall=1 for 3 cycles while EX holds rd=9 and i_flush pulses in cycle 2 -> EX contents unchanged (rd=9, valid=1) throughout; o_id_hold=1.
- WB bypass: i_wb_rd=3, i_wb_reg_write=1, i_wb_data=0xDEADBEEF, ID rs1=3, i_id_rs1_data=0 -> o_ex_rs1_data=0xDEADBEEF; with i_wb_rd=0 -> o_ex_rs1_data=0.
